// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MDU_FAST_MUL_EN enables a single-cycle multiply path
module mdu_hilo #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  logic [1:0] state;
  logic div_q, neg_q, rneg_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2*DATA_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic sgn, fast_mul, dz;
  logic [DATA_W-1:0] a_abs, b_abs, quo, rem, a_raw, hi_fix, lo_fix;
  logic [DATA_W:0] mul_sum, rem_sh;
  logic [DATA_W+1:0] div_diff;
  logic [2*DATA_W-1:0] acc_init, acc_step, prod;
  always_comb begin
    sgn = ~op[0];
    a_abs = (sgn & src_a[DATA_W-1]) ? -src_a : src_a;
    b_abs = (sgn & src_b[DATA_W-1]) ? -src_b : src_b;
`ifdef MDU_FAST_MUL_EN
    fast_mul = ~op[1];
    acc_init = fast_mul ? {{DATA_W{1'b0}}, a_abs} * {{DATA_W{1'b0}}, b_abs} : {{DATA_W{1'b0}}, a_abs};
`else
    fast_mul = 1'b0;
    acc_init = {{DATA_W{1'b0}}, a_abs};
`endif
    // multiply: shift-add into the upper half; divide: restoring step on {rem, quotient}
    mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b_q} : '0);
    rem_sh = acc[2*DATA_W-1:DATA_W-1];
    div_diff = {1'b0, rem_sh} - {2'b0, b_q};
    acc_step = !div_q ? {mul_sum, acc[DATA_W-1:1]}
             : div_diff[DATA_W+1] ? {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
             : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    dz = b_q == '0;
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    rem = rneg_q ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    a_raw = rneg_q ? -a_q : a_q;
    hi_fix = !div_q ? prod[2*DATA_W-1:DATA_W] : dz ? a_raw : rem;
    lo_fix = !div_q ? prod[DATA_W-1:0] : dz ? '1 : quo;
  end
  assign busy = state != IDLE;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      HI <= '0;
      LO <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_q <= op[1];
            a_q <= a_abs;
            b_q <= b_abs;
            neg_q <= sgn & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            rneg_q <= sgn & src_a[DATA_W-1];
            acc <= acc_init;
            cnt <= '0;
            state <= fast_mul ? FIX : CALC;
          end else begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= FIX;
        end
        FIX: begin
          HI <= hi_fix;
          LO <= lo_fix;
          done <= 1'b1;
          div_by_zero <= div_q & dz;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
